// File: rtl/fir_pkg.sv
// Shared FIR coefficient-bank types and constants.
// Holds the commit FSM state encoding and index sizing.
package fir_pkg;

  localparam int FIR_COEFS_NR = 8;
  localparam int FIR_IDX_W = $clog2(FIR_COEFS_NR) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_DONE = 2'd2
  } fir_state_e;

  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level request input.
// Stays disarmed for one cycle after reset so a level already high is ignored.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_rise
);

  logic r_prev;
  logic r_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_arm  <= 1'b0;
    end else begin
      r_prev <= i_lvl;
      r_arm  <= 1'b1;
    end
  end

  assign o_rise = i_lvl & ~r_prev & r_arm;

endmodule

// File: rtl/coef_bank_loader.sv
// Shadow/active FIR coefficient bank with a sequential commit engine.
// Writes land in the shadow bank; a request edge copies it to the active bank.
module coef_bank_loader
  import fir_pkg::*;
#(
  parameter int FIR_COEF_WIDTH     = 18,
  parameter int FIR_DSP_NR         = 4,
  parameter int FIR_TM             = 2,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  localparam int L_N   = FIR_TM * FIR_DSP_NR,
  localparam int IDX_W = idx_w(L_N),
  localparam int W     = FIR_COEF_WIDTH,
  localparam int DW    = C_S_AXI_DATA_WIDTH
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             wr_valid,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_data,
  input  logic             update_req,
  input  logic [DW-1:0]    coefs_crr_nr,
  input  logic             flag_clr,
  output logic [L_N*W-1:0] coefs_flat,
  output logic             busy,
  output logic             done,
  output logic [7:0]       generation,
  output logic             err_idx,
  output logic             wr_drop
);

  localparam int PTR_W = IDX_W - 1;
  localparam logic [IDX_W-1:0] L_N_IDX = IDX_W'(L_N);
  localparam logic [PTR_W-1:0] L_LAST = PTR_W'(L_N - 1);

  fir_state_e r_state;
  fir_state_e w_next;

  logic [W-1:0]     r_shadow [L_N];
  logic [W-1:0]     r_active [L_N];
  logic [PTR_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_nc;
  logic [7:0]       r_gen;
  logic             r_err;
  logic             r_drop;

  logic             w_rise;
  logic             w_idle;
  logic             w_in_rng;
  logic [IDX_W-1:0] w_nc;
  logic [W-1:0]     w_coef;
  logic             w_unused;

  edge_detect u_edge (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .i_lvl  (update_req),
    .o_rise (w_rise)
  );

  assign w_idle   = (r_state == ST_IDLE);
  assign w_in_rng = (wr_idx < L_N_IDX);
  assign w_nc     = (coefs_crr_nr >= DW'(L_N)) ? L_N_IDX
                                               : coefs_crr_nr[IDX_W-1:0];
  // Sign bit of the register word becomes the coefficient MSB.
  assign w_coef   = {wr_data[DW-1], wr_data[W-2:0]};
  assign w_unused = ^wr_data[DW-2:W-1];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_rise) w_next = ST_COPY;
      ST_COPY: if (r_ptr == L_LAST) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int k = 0; k < L_N; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      r_ptr <= '0;
      r_nc  <= '0;
      r_gen <= '0;
    end else begin
      if (wr_valid && w_idle && w_in_rng)
        r_shadow[wr_idx[PTR_W-1:0]] <= w_coef;
      if (w_idle && w_rise) begin
        r_nc  <= w_nc;
        r_ptr <= '0;
      end
      if (r_state == ST_COPY) begin
        r_active[r_ptr] <= ({1'b0, r_ptr} < r_nc) ? r_shadow[r_ptr] : '0;
        r_ptr <= r_ptr + 1'b1;
      end
      if (r_state == ST_DONE)
        r_gen <= r_gen + 8'd1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_err  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (wr_valid && !w_in_rng) r_err <= 1'b1;
      else if (flag_clr)         r_err <= 1'b0;
      if (wr_valid && !w_idle)   r_drop <= 1'b1;
      else if (flag_clr)         r_drop <= 1'b0;
    end
  end

  for (genvar g = 0; g < L_N; g++) begin : g_flat
    assign coefs_flat[g*W +: W] = r_active[g];
  end

  assign busy       = (r_state == ST_COPY);
  assign done       = (r_state == ST_DONE);
  assign generation = r_gen;
  assign err_idx    = r_err;
  assign wr_drop    = r_drop;

endmodule

// File: tb/tb_coef_bank_loader.sv
// Scoreboard bench for coef_bank_loader: commits queue expectations,
// a monitor pops and compares on every done pulse.
module tb_coef_bank_loader;
  import fir_pkg::*;

  localparam int W  = 18;
  localparam int N  = FIR_COEFS_NR;
  localparam int FW = N * W;

  typedef struct {
    logic [FW-1:0] flat;
    logic [7:0]    gen;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wr_valid = 1'b0;
  logic [FIR_IDX_W-1:0] wr_idx = '0;
  logic [31:0]          wr_data = '0;
  logic                 update_req = 1'b0;
  logic [31:0]          coefs_crr_nr = '0;
  logic                 flag_clr = 1'b0;
  logic [FW-1:0]        coefs_flat;
  logic                 busy;
  logic                 done;
  logic [7:0]           generation;
  logic                 err_idx;
  logic                 wr_drop;

  int   n_chk = 0;
  int   n_fail = 0;
  int   gen_exp = 0;
  logic [W-1:0] sh [N];
  exp_t q[$];

  coef_bank_loader dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .wr_valid      (wr_valid),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .update_req    (update_req),
    .coefs_crr_nr  (coefs_crr_nr),
    .flag_clr      (flag_clr),
    .coefs_flat    (coefs_flat),
    .busy          (busy),
    .done          (done),
    .generation    (generation),
    .err_idx       (err_idx),
    .wr_drop       (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkexp(input int n);
    logic [FW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (k < n) r[k*W +: W] = sh[k];
    return r;
  endfunction

  task automatic push_exp(input int n);
    exp_t e;
    gen_exp = (gen_exp + 1) % 256;
    e.flat = mkexp(n);
    e.gen  = 8'(gen_exp);
    q.push_back(e);
  endtask

  task automatic wr(input int i, input logic [31:0] d);
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_idx   = 4'(i);
    wr_data  = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic commit(input int n);
    push_exp(n);
    @(posedge clk); #1;
    coefs_crr_nr = 32'(n);
    update_req   = 1'b1;
    @(negedge clk);
    chk("busy_edge_cycle", FW'(busy), FW'(0));
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      chk("busy_copy", FW'(busy), FW'(1));
      if (i == 2) coefs_crr_nr = 32'd0;
    end
    @(negedge clk);
    chk("done_pulse", FW'(done), FW'(1));
    chk("busy_at_done", FW'(busy), FW'(0));
    @(posedge clk); #1;
    update_req = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected_done: got done=1 expected no commit");
        end else begin
          e = q.pop_front();
          @(negedge clk);
          chk("sb_flat", coefs_flat, e.flat);
          chk("sb_gen", FW'(generation), FW'(e.gen));
        end
      end
    end
  end

  initial begin : stim
    int cnt;
    for (int k = 0; k < N; k++) sh[k] = '0;
    repeat (2) @(negedge clk);
    chk("rst_flat", coefs_flat, '0);
    chk("rst_busy", FW'(busy), FW'(0));
    chk("rst_gen", FW'(generation), FW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < N; k++) begin
      wr(k, 32'(k + 1));
      sh[k] = 18'(k + 1);
    end
    commit(8);
    commit(3);
    commit(100);
    commit(0);

    wr(2, 32'h8000_0001);
    sh[2] = 18'h20001;
    wr(8, 32'h0000_0055);
    @(negedge clk);
    chk("err_idx_set", FW'(err_idx), FW'(1));
    @(posedge clk); #1 flag_clr = 1'b1;
    @(posedge clk); #1 flag_clr = 1'b0;
    @(negedge clk);
    chk("err_idx_clr", FW'(err_idx), FW'(0));
    commit(8);

    push_exp(8);
    @(posedge clk); #1;
    coefs_crr_nr = 32'd8;
    update_req   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wr_valid   = 1'b1;
    wr_idx     = 4'd0;
    wr_data    = 32'd99;
    update_req = 1'b0;
    @(posedge clk); #1;
    wr_valid   = 1'b0;
    update_req = 1'b1;
    cnt = 0;
    while (done !== 1'b1 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    chk("drop_done_timeout", FW'(cnt < 30), FW'(1));
    chk("wr_drop_set", FW'(wr_drop), FW'(1));
    @(posedge clk); #1 update_req = 1'b0;
    repeat (12) @(posedge clk);
    commit(8);

    @(posedge clk); #1;
    flag_clr = 1'b1;
    wr_valid = 1'b1;
    wr_idx   = 4'd9;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("err_set_priority", FW'(err_idx), FW'(1));
    chk("wr_drop_clr", FW'(wr_drop), FW'(0));

    @(posedge clk); #1;
    coefs_crr_nr = 32'd8;
    update_req   = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_flat", coefs_flat, '0);
    chk("arst_busy", FW'(busy), FW'(0));
    chk("arst_done", FW'(done), FW'(0));
    chk("arst_gen", FW'(generation), FW'(0));
    chk("arst_flags", FW'({err_idx, wr_drop}), FW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
    end
    chk("no_commit_held_high", FW'(cnt), FW'(0));

    gen_exp = 0;
    for (int k = 0; k < N; k++) sh[k] = '0;
    update_req = 1'b0;
    repeat (2) @(posedge clk);
    commit(8);

    repeat (4) @(negedge clk);
    chk("sb_empty", FW'(q.size()), FW'(0));
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/coef_bank_loader.md
COEF_BANK_LOADER -- requirements
Module: coef_bank_loader

Interface
REQ-001 SHALL have parameter FIR_COEF_WIDTH, default 18: coefficient width in bits.
REQ-002 SHALL have parameter FIR_DSP_NR, default 4: number of DSP taps.
REQ-003 SHALL have parameter FIR_TM, default 2: time-multiplex factor; FIR_COEFS_NR = FIR_TM*FIR_DSP_NR.
REQ-004 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: register data width.
REQ-005 S_AXI_ACLK  in  1  the single clock, all logic on its rising edge.
REQ-006 S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-007 wr_valid  in  1  one-cycle shadow-write strobe from the AXI write mapping.
REQ-008 wr_idx  in  $clog2(FIR_COEFS_NR)+1  coefficient index.
REQ-009 wr_data  in  C_S_AXI_DATA_WIDTH  raw register word.
REQ-010 update_req  in  1  level input (switch bit 2); its rising edge requests a commit.
REQ-011 coefs_crr_nr  in  C_S_AXI_DATA_WIDTH  number of active coefficients N.
REQ-012 flag_clr  in  1  clears the sticky flags.
REQ-013 coefs_flat  out  FIR_COEFS_NR*FIR_COEF_WIDTH  active bank; coefficient k at bits [k*W +: W].
REQ-014 busy  out  1  commit in progress.
REQ-015 done  out  1  one-cycle pulse at the end of a commit.
REQ-016 generation  out  8  commit counter.
REQ-017 err_idx  out  1  sticky flag: out-of-range write.
REQ-018 wr_drop  out  1  sticky flag: write dropped while busy.

Function
REQ-019 Shadow write SHALL occur when wr_valid=1, the state is IDLE, and wr_idx<FIR_COEFS_NR; the stored value is {wr_data[C_S_AXI_DATA_WIDTH-1], wr_data[FIR_COEF_WIDTH-2:0]}.
REQ-020 If wr_valid=1 and wr_idx>=FIR_COEFS_NR, the write SHALL be ignored and err_idx set to 1.
REQ-021 If wr_valid=1 while the state is not IDLE, the write SHALL be ignored and wr_drop set to 1.
REQ-022 flag_clr=1 SHALL clear both flags next cycle; a simultaneous set event SHALL take priority.
REQ-023 A rising edge SHALL be detected with a registered copy of update_req; an edge seen outside IDLE SHALL be discarded, never queued.
REQ-024 FSM SHALL have exactly three states:
- IDLE: on edge, latch Nc = min(coefs_crr_nr, FIR_COEFS_NR), set ptr=0, go to COPY.
- COPY: one coefficient per cycle; active[ptr] <= (ptr<Nc) ? shadow[ptr] : 0; go to DONE after ptr=FIR_COEFS_NR-1.
- DONE: one cycle, then IDLE.
REQ-025 Timing, for an edge sampled at cycle t:
- busy SHALL be 1 in cycles t+1..t+FIR_COEFS_NR.
- active[k] SHALL update at the end of cycle t+1+k.
- done SHALL be 1 in cycle t+1+FIR_COEFS_NR only, with busy=0 in that cycle.
REQ-026 generation SHALL increment by 1 in the DONE state and wrap from 255 to 0.
REQ-027 Nc=0 SHALL zero the whole active bank; coefs_crr_nr changes during COPY SHALL have no effect.
REQ-028 coefs_flat SHALL be registered outputs with no combinational path from any input.

Reset
REQ-029 While S_AXI_ARESETN=0, the following SHALL be 0 immediately, including mid-COPY: state (IDLE), shadow bank, active bank, ptr, Nc, edge register, busy, done, generation, err_idx, wr_drop.
REQ-030 After reset release, an update_req already high SHALL NOT trigger a commit; a low-to-high transition is required.

Structure
REQ-031 A shared package fir_pkg SHALL hold the FSM state enum, FIR_COEFS_NR, and the index width.
REQ-032 The rising-edge detector SHALL be a sub-module named edge_detect.

Verification
REQ-033 Write idx0..7 = 1..8, N=8, raise update_req -> busy for 8 cycles, done at t+9, active = 1..8, generation=1.
REQ-034 Same shadow, N=3 -> active = 1,2,3,0,0,0,0,0; N=100 -> all 8 copied.
REQ-035 wr_data=0x80000001 at idx2 -> shadow[2] = 18'h20001; write at idx 8 -> err_idx=1, bank unchanged; flag_clr -> err_idx=0.
REQ-036 Write during COPY, plus a toggle of update_req during COPY -> wr_drop=1, exactly one done pulse, shadow unchanged.
REQ-037 Assert reset at ptr=4 -> all outputs 0 asynchronously; release with update_req held high -> no commit until a new edge.
